// File: rtl/pc_fetch.sv
// Purpose: program counter, branch resolution and fetch request for the single-cycle CPU.
// Latency: one cycle from an advance to pc/taken/counter update; outputs are purely registered.
// Backpressure: imem_ready low or stall high holds all state; HALT waits for a resume pulse.
module pc_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        resume,
  input  logic [2:0]  br_type,
  input  logic [63:0] br_target,
  input  logic [63:0] reg_target,
  input  logic        alu_zero,
  input  logic        negative,
  input  logic        zero,
  input  logic        overflow,
  input  logic        carry_out,
  input  logic        imem_ready,
  output logic [63:0] pc,
  output logic        imem_req,
  output logic        taken,
  output logic        halted,
  output logic [31:0] taken_count,
  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_B    = 3'b001;
  localparam logic [2:0] BR_CBZ  = 3'b010;
  localparam logic [2:0] BR_BLT  = 3'b011;
  localparam logic [2:0] BR_BEQ  = 3'b100;
  localparam logic [2:0] BR_BNE  = 3'b101;
  localparam logic [2:0] BR_BR   = 3'b110;
  localparam logic [2:0] BR_HALT = 3'b111;

  state_t      state, state_nxt;
  logic [63:0] pc_nxt;
  logic        taken_nxt;
  logic [31:0] taken_count_nxt;
  logic [31:0] retired_count_nxt;
  logic        advance;
  logic        cond;

  // carry_out has no consumer yet; BR targets are word aligned so the low bits are dropped.
  logic unused_ok;
  assign unused_ok = ^{carry_out, reg_target[1:0], BR_NONE, BR_HALT};

  // Evaluate the branch condition for the current instruction class.
  always_comb begin
    cond = 1'b0;
    case (br_type)
      BR_B, BR_BR: cond = 1'b1;
      BR_CBZ:      cond = alu_zero;
      BR_BLT:      cond = negative ^ overflow;
      BR_BEQ:      cond = zero;
      BR_BNE:      cond = ~zero;
      default:     cond = 1'b0;
    endcase
  end

  assign advance = (state == ST_RUN) && imem_ready && !stall;

  // Next-state, next-PC and counter updates; everything holds unless explicitly changed.
  always_comb begin
    state_nxt         = state;
    pc_nxt            = pc;
    taken_nxt         = 1'b0;
    taken_count_nxt   = taken_count;
    retired_count_nxt = retired_count;
    case (state)
      ST_IDLE: state_nxt = ST_RUN;
      ST_RUN: begin
        if (advance) begin
          retired_count_nxt = retired_count + 32'd1;
          taken_nxt         = cond;
          if (cond && br_type == BR_BR)
            pc_nxt = {reg_target[63:2], 2'b00};
          else if (cond)
            pc_nxt = br_target;
          else
            pc_nxt = pc + 64'd4;
          if (cond && taken_count != 32'hFFFF_FFFF)
            taken_count_nxt = taken_count + 32'd1;
          if (br_type == BR_HALT)
            state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        if (resume)
          state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, PC, pulse and counter registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      pc            <= RESET_PC;
      taken         <= 1'b0;
      taken_count   <= 32'd0;
      retired_count <= 32'd0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      taken         <= taken_nxt;
      taken_count   <= taken_count_nxt;
      retired_count <= retired_count_nxt;
    end
  end

  assign imem_req = (state == ST_RUN);
  assign halted   = (state == ST_HALT);

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        resume;
  logic [2:0]  br_type;
  logic [63:0] br_target;
  logic [63:0] reg_target;
  logic        alu_zero;
  logic        negative;
  logic        zero;
  logic        overflow;
  logic        carry_out;
  logic        imem_ready;
  logic [63:0] pc;
  logic        imem_req;
  logic        taken;
  logic        halted;
  logic [31:0] taken_count;
  logic [31:0] retired_count;

  int checks = 0;
  int errors = 0;

  pc_fetch #(.RESET_PC(64'h100)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .resume       (resume),
    .br_type      (br_type),
    .br_target    (br_target),
    .reg_target   (reg_target),
    .alu_zero     (alu_zero),
    .negative     (negative),
    .zero         (zero),
    .overflow     (overflow),
    .carry_out    (carry_out),
    .imem_ready   (imem_ready),
    .pc           (pc),
    .imem_req     (imem_req),
    .taken        (taken),
    .halted       (halted),
    .taken_count  (taken_count),
    .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction presented with imem_ready=1, no stall.
  task automatic issue(input logic [2:0] bt, input logic [63:0] tgt);
    br_type    = bt;
    br_target  = tgt;
    imem_ready = 1'b1;
    stall      = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; resume = 1'b0; br_type = 3'b000;
    br_target = 64'h0; reg_target = 64'h0; alu_zero = 1'b0;
    negative = 1'b0; zero = 1'b0; overflow = 1'b0; carry_out = 1'b0;
    imem_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_eq("rst_pc", pc, 64'h100);
    check_eq("rst_req", {63'd0, imem_req}, 64'd0);
    check_eq("rst_halted", {63'd0, halted}, 64'd0);
    check_eq("rst_taken", {63'd0, taken}, 64'd0);
    check_eq("rst_tcnt", {32'd0, taken_count}, 64'd0);
    check_eq("rst_rcnt", {32'd0, retired_count}, 64'd0);
    tick();
    check_eq("rst_hold_req", {63'd0, imem_req}, 64'd0);
    reset = 1'b1;
    tick();
    check_eq("run_req", {63'd0, imem_req}, 64'd1);
    check_eq("run_pc", pc, 64'h100);

    // Sequential fetch
    issue(3'b000, 64'h0);
    check_eq("seq_pc1", pc, 64'h104);
    check_eq("seq_tk1", {63'd0, taken}, 64'd0);
    issue(3'b000, 64'h0);
    check_eq("seq_pc2", pc, 64'h108);
    check_eq("seq_tk2", {63'd0, taken}, 64'd0);
    issue(3'b000, 64'h0);
    check_eq("seq_pc3", pc, 64'h10C);
    check_eq("seq_tk3", {63'd0, taken}, 64'd0);
    check_eq("seq_rcnt", {32'd0, retired_count}, 64'd3);

    // Handshake holds
    issue(3'b001, 64'h10);
    check_eq("b_pc", pc, 64'h10);
    check_eq("b_tk", {63'd0, taken}, 64'd1);
    br_type = 3'b001; br_target = 64'h80; imem_ready = 1'b0; stall = 1'b0;
    tick();
    check_eq("nrdy1_pc", pc, 64'h10);
    check_eq("nrdy1_tk", {63'd0, taken}, 64'd0);
    tick();
    check_eq("nrdy2_pc", pc, 64'h10);
    imem_ready = 1'b1; stall = 1'b1;
    tick();
    check_eq("stall_pc", pc, 64'h10);
    check_eq("stall_tk", {63'd0, taken}, 64'd0);
    check_eq("stall_rcnt", {32'd0, retired_count}, 64'd4);
    issue(3'b001, 64'h80);
    check_eq("hs_pc", pc, 64'h80);
    check_eq("hs_tk", {63'd0, taken}, 64'd1);
    issue(3'b000, 64'h0);
    check_eq("hs_next_pc", pc, 64'h84);
    check_eq("hs_tk_off", {63'd0, taken}, 64'd0);

    // Conditions
    negative = 1'b1; overflow = 1'b0;
    issue(3'b011, 64'h200);
    check_eq("blt_t_pc", pc, 64'h200);
    check_eq("blt_t_tk", {63'd0, taken}, 64'd1);
    negative = 1'b1; overflow = 1'b1;
    issue(3'b011, 64'h900);
    check_eq("blt_nt_pc", pc, 64'h204);
    check_eq("blt_nt_tk", {63'd0, taken}, 64'd0);
    negative = 1'b0; overflow = 1'b0; alu_zero = 1'b1; zero = 1'b0;
    issue(3'b010, 64'h400);
    check_eq("cbz_pc", pc, 64'h400);
    alu_zero = 1'b0;
    issue(3'b100, 64'h900);
    check_eq("beq_nt_pc", pc, 64'h404);
    issue(3'b101, 64'h500);
    check_eq("bne_t_pc", pc, 64'h500);
    reg_target = 64'h3003;
    issue(3'b110, 64'h900);
    check_eq("br_pc", pc, 64'h3000);
    check_eq("br_tk", {63'd0, taken}, 64'd1);
    check_eq("cond_rcnt", {32'd0, retired_count}, 64'd12);
    check_eq("cond_tcnt", {32'd0, taken_count}, 64'd6);

    // Halt / resume, with resume colliding with the HALT advance
    issue(3'b001, 64'h50);
    check_eq("pre_halt_pc", pc, 64'h50);
    resume = 1'b1;
    issue(3'b111, 64'h900);
    resume = 1'b0;
    check_eq("halt_halted", {63'd0, halted}, 64'd1);
    check_eq("halt_pc", pc, 64'h54);
    check_eq("halt_req", {63'd0, imem_req}, 64'd0);
    check_eq("halt_tk", {63'd0, taken}, 64'd0);
    check_eq("halt_rcnt", {32'd0, retired_count}, 64'd14);
    br_type = 3'b001; br_target = 64'h999;
    for (int i = 0; i < 5; i++) begin
      stall = i[0];
      imem_ready = ~i[1];
      tick();
      check_eq("halt_hold_pc", pc, 64'h54);
      check_eq("halt_hold_h", {63'd0, halted}, 64'd1);
    end
    check_eq("halt_hold_rcnt", {32'd0, retired_count}, 64'd14);
    stall = 1'b0; imem_ready = 1'b1; br_type = 3'b000; resume = 1'b1;
    tick();
    resume = 1'b0;
    check_eq("resume_h", {63'd0, halted}, 64'd0);
    check_eq("resume_req", {63'd0, imem_req}, 64'd1);
    check_eq("resume_pc", pc, 64'h54);
    issue(3'b000, 64'h0);
    check_eq("resume_adv_pc", pc, 64'h58);
    check_eq("resume_rcnt", {32'd0, retired_count}, 64'd15);

    // PC wrap
    issue(3'b001, 64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("wrap_pre_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    issue(3'b000, 64'h0);
    check_eq("wrap_pc", pc, 64'h0);

    // Retired counter wrap
    stall = 1'b1;
    force dut.retired_count = 32'hFFFF_FFFF;
    tick();
    release dut.retired_count;
    #1;
    check_eq("rcnt_forced", {32'd0, retired_count}, 64'hFFFF_FFFF);
    issue(3'b000, 64'h0);
    check_eq("rcnt_wrap", {32'd0, retired_count}, 64'd0);
    check_eq("rcnt_wrap_pc", pc, 64'h4);

    // Taken counter saturation
    stall = 1'b1;
    force dut.taken_count = 32'hFFFF_FFFF;
    tick();
    release dut.taken_count;
    #1;
    issue(3'b001, 64'h700);
    check_eq("tcnt_sat", {32'd0, taken_count}, 64'hFFFF_FFFF);
    check_eq("tcnt_sat_pc", pc, 64'h700);
    check_eq("tcnt_sat_tk", {63'd0, taken}, 64'd1);

    // Asynchronous reset mid-run
    issue(3'b001, 64'h240);
    check_eq("mid_pc", pc, 64'h240);
    #2 reset = 1'b0;
    #1;
    check_eq("arst_pc", pc, 64'h100);
    check_eq("arst_req", {63'd0, imem_req}, 64'd0);
    check_eq("arst_tcnt", {32'd0, taken_count}, 64'd0);
    check_eq("arst_rcnt", {32'd0, retired_count}, 64'd0);
    check_eq("arst_tk", {63'd0, taken}, 64'd0);
    tick();
    check_eq("arst_hold_pc", pc, 64'h100);
    reset = 1'b1;
    tick();
    check_eq("arst_rel_req", {63'd0, imem_req}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
